// File: rtl/vision_pkg.sv
// Shared widths, divider length, FSM encoding and small helpers for the
// vision statistics blocks (mask_centroid, seq_divider).
package vision_pkg;
  localparam int COORD_W  = 10;
  localparam int AREA_W   = 20;
  localparam int MOM_W    = 30;
  localparam int DIV_ITER = 30;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } cent_state_e;

  typedef struct packed {
    logic [AREA_W-1:0] m00;
    logic [MOM_W-1:0]  m10;
    logic [MOM_W-1:0]  m01;
  } moments_t;

  typedef struct packed {
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
  } bbox_t;

  // Min fields start at all-ones so the first mask pixel always wins.
  localparam bbox_t BBOX_EMPTY = '{
    xmin: {COORD_W{1'b1}}, xmax: '0,
    ymin: {COORD_W{1'b1}}, ymax: '0
  };

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per enabled cycle, DIV_ITER
// cycles per division. quotient is final in the cycle done is high.
module seq_divider
  import vision_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              start,
  input  logic [MOM_W-1:0]  dividend,
  input  logic [AREA_W-1:0] divisor,
  output logic              done,
  output logic [MOM_W-1:0]  quotient
);
  localparam int CNT_W = $clog2(DIV_ITER);

  logic [AREA_W-1:0] rem_q, rem_d, dvs_q, dvs_d;
  logic [MOM_W-1:0]  quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic [AREA_W:0]   shifted, diff;

  always_comb begin
    shifted = {rem_q, quo_q[MOM_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    done    = busy_q && (cnt_q == CNT_W'(DIV_ITER - 1));
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvs_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Dividend bits shift out of the top of quo while quotient bits enter below.
      if (diff[AREA_W]) begin
        rem_d = shifted[AREA_W-1:0];
        quo_d = {quo_q[MOM_W-2:0], 1'b0};
      end else begin
        rem_d = diff[AREA_W-1:0];
        quo_d = {quo_q[MOM_W-2:0], 1'b1};
      end
      cnt_d  = cnt_q + 1'b1;
      busy_d = !done;
    end
  end

  assign quotient = quo_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (ce) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end
endmodule

// File: rtl/mask_centroid.sv
// Per-frame mask area, centroid and (with MASK_CENTROID_BBOX_EN defined)
// bounding box, computed from the closed binary mask and its de/vsync timing.
module mask_centroid
  import vision_pkg::*;
#(
  parameter logic [COORD_W-1:0] H_SIZE = 10'd640,
  parameter logic [COORD_W-1:0] V_SIZE = 10'd480
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               mask,
  input  logic               in_de,
  input  logic               in_vsync,
  output logic [AREA_W-1:0]  area,
  output logic [COORD_W-1:0] cx,
  output logic [COORD_W-1:0] cy,
  output logic               found,
  output logic               valid,
  output logic               busy,
  output logic               overrun,
  output logic [COORD_W-1:0] bbox_xmin,
  output logic [COORD_W-1:0] bbox_xmax,
  output logic [COORD_W-1:0] bbox_ymin,
  output logic [COORD_W-1:0] bbox_ymax
);
  cent_state_e state_q, state_d;

  logic               vsync_q, de_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  moments_t           acc_q, acc_d;
  logic               empty_q, empty_d;
  logic [AREA_W-1:0]  snap_area_q, snap_area_d;
  logic [AREA_W-1:0]  area_q, area_d;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic               found_q, found_d, valid_q, valid_d, overrun_q, overrun_d;

  logic frame_end, de_fall, hit, accept;
  logic div_start, load_div, load_empty;
  logic [1:0][MOM_W-1:0] div_dividend, div_quot;
  logic [1:0]            div_done;
  logic                  unused_div;

  assign frame_end = in_vsync && !vsync_q;
  assign de_fall   = de_q && !in_de;
  assign hit       = in_de && mask && (x_q < H_SIZE) && (y_q < V_SIZE);
  assign accept    = frame_end && (state_q == ST_IDLE);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (frame_end) begin
      x_d = '0;
      y_d = '0;
    end else if (de_fall) begin
      x_d = '0;
      y_d = sat_inc(y_q);
    end else if (in_de) begin
      x_d = sat_inc(x_q);
    end
  end

  // Clearing and accumulating in one cycle keeps a pixel coincident with frame end.
  always_comb begin
    acc_d = frame_end ? '0 : acc_q;
    if (hit) begin
      acc_d.m00 = acc_d.m00 + 1'b1;
      acc_d.m10 = acc_d.m10 + MOM_W'(x_q);
      acc_d.m01 = acc_d.m01 + MOM_W'(y_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else if (ce) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = (acc_q.m00 != '0) ? ST_DIV : ST_DONE;
      ST_DIV:  if (div_done[0]) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Divider path publishes on its last iteration; the empty path publishes from DONE.
  always_comb begin
    div_start  = accept && (acc_q.m00 != '0);
    load_div   = (state_q == ST_DIV) && div_done[0];
    load_empty = (state_q == ST_DONE) && empty_q;
    busy       = (state_q == ST_DIV);
  end

  assign div_dividend = {acc_q.m01, acc_q.m10};

  for (genvar a = 0; a < 2; a++) begin : g_axis
    seq_divider u_div (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .start    (div_start),
      .dividend (div_dividend[a]),
      .divisor  (acc_q.m00),
      .done     (div_done[a]),
      .quotient (div_quot[a])
    );
  end

  assign unused_div = ^{div_quot[0][MOM_W-1:COORD_W], div_quot[1][MOM_W-1:COORD_W], div_done[1]};

  always_comb begin
    snap_area_d = accept ? acc_q.m00 : snap_area_q;
    empty_d     = accept ? (acc_q.m00 == '0) : empty_q;
    area_d      = area_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    found_d     = found_q;
    valid_d     = load_div || load_empty;
    overrun_d   = frame_end && (state_q != ST_IDLE);
    if (load_div) begin
      area_d  = snap_area_q;
      cx_d    = div_quot[0][COORD_W-1:0];
      cy_d    = div_quot[1][COORD_W-1:0];
      found_d = 1'b1;
    end else if (load_empty) begin
      area_d  = '0;
      cx_d    = '0;
      cy_d    = '0;
      found_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q     <= 1'b0;
      de_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      empty_q     <= 1'b0;
      snap_area_q <= '0;
      area_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      found_q     <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (ce) begin
      vsync_q     <= in_vsync;
      de_q        <= in_de;
      x_q         <= x_d;
      y_q         <= y_d;
      acc_q       <= acc_d;
      empty_q     <= empty_d;
      snap_area_q <= snap_area_d;
      area_q      <= area_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      found_q     <= found_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign area    = area_q;
  assign cx      = cx_q;
  assign cy      = cy_q;
  assign found   = found_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

`ifdef MASK_CENTROID_BBOX_EN
  bbox_t run_q, run_d, snap_q, snap_d, bbox_q, bbox_d;

  always_comb begin
    run_d = frame_end ? BBOX_EMPTY : run_q;
    if (hit) begin
      if (x_q < run_d.xmin) run_d.xmin = x_q;
      if (x_q > run_d.xmax) run_d.xmax = x_q;
      if (y_q < run_d.ymin) run_d.ymin = y_q;
      if (y_q > run_d.ymax) run_d.ymax = y_q;
    end
    snap_d = accept ? run_q : snap_q;
    bbox_d = bbox_q;
    if (load_div) bbox_d = snap_q;
    else if (load_empty) bbox_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= BBOX_EMPTY;
      snap_q <= '0;
      bbox_q <= '0;
    end else if (ce) begin
      run_q  <= run_d;
      snap_q <= snap_d;
      bbox_q <= bbox_d;
    end
  end

  assign bbox_xmin = bbox_q.xmin;
  assign bbox_xmax = bbox_q.xmax;
  assign bbox_ymin = bbox_q.ymin;
  assign bbox_ymax = bbox_q.ymax;
`else
  assign bbox_xmin = '0;
  assign bbox_xmax = '0;
  assign bbox_ymin = '0;
  assign bbox_ymax = '0;
`endif
endmodule

// File: tb/tb_mask_centroid.sv
// Scoreboard bench for mask_centroid on an 8x4 frame: expected results are
// modelled from the driven mask and popped when the DUT pulses valid.
module tb_mask_centroid;
  logic clk = 1'b0;
  logic rst, ce, mask, in_de, in_vsync;
  logic [19:0] area;
  logic [9:0]  cx, cy, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
  logic        found, valid, busy, overrun;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  int n_ovr = 0;
  bit busy_seen = 1'b0;

  typedef struct {
    int area, cx, cy, found, xmin, xmax, ymin, ymax, due;
  } exp_t;
  exp_t sb[$];

  mask_centroid #(.H_SIZE(10'd8), .V_SIZE(10'd4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mask(mask), .in_de(in_de), .in_vsync(in_vsync),
    .area(area), .cx(cx), .cy(cy), .found(found), .valid(valid), .busy(busy),
    .overrun(overrun), .bbox_xmin(bbox_xmin), .bbox_xmax(bbox_xmax),
    .bbox_ymin(bbox_ymin), .bbox_ymax(bbox_ymax)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] m);
    exp_t e;
    int sx, sy;
    e = '{default: 0};
    e.xmin = 99;
    e.ymin = 99;
    sx = 0;
    sy = 0;
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        if (m[y*8+x]) begin
          e.area++;
          sx += x;
          sy += y;
          if (x < e.xmin) e.xmin = x;
          if (x > e.xmax) e.xmax = x;
          if (y < e.ymin) e.ymin = y;
          if (y > e.ymax) e.ymax = y;
        end
    if (e.area != 0) begin
      e.found = 1;
      e.cx = sx / e.area;
      e.cy = sy / e.area;
    end else begin
      e.xmin = 0;
      e.ymin = 0;
    end
`ifndef MASK_CENTROID_BBOX_EN
    e.xmin = 0;
    e.xmax = 0;
    e.ymin = 0;
    e.ymax = 0;
`endif
    return e;
  endfunction

  // Pixels outside the 8x4 active area are driven as mask=1 and must be ignored.
  task automatic send_lines(input logic [31:0] m, input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        in_de = 1'b1;
        mask  = (x < 8 && y < 4) ? m[y*8+x] : 1'b1;
        tick();
      end
      in_de = 1'b0;
      mask  = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic vsync_rise(input logic [31:0] m, input bit push, input int stall, output int t);
    exp_t e;
    e = model(m);
    t = cyc;
    e.due = t + ((e.area != 0) ? 31 : 2) + stall;
    if (push) sb.push_back(e);
    in_de = 1'b0;
    in_vsync = 1'b1;
    tick();
    tick();
    in_vsync = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      tick();
      n++;
    end
    chk("idle_in_time", int'(n < 300), 1);
    repeat (4) tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (overrun) n_ovr++;
      if (valid) begin
        n_valid++;
        chk("valid_expected", int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("latency", cyc, e.due);
          chk("area", int'(area), e.area);
          chk("cx", int'(cx), e.cx);
          chk("cy", int'(cy), e.cy);
          chk("found", int'(found), e.found);
          chk("bbox_xmin", int'(bbox_xmin), e.xmin);
          chk("bbox_xmax", int'(bbox_xmax), e.xmax);
          chk("bbox_ymin", int'(bbox_ymin), e.ymin);
          chk("bbox_ymax", int'(bbox_ymax), e.ymax);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, t2, nv, no;
    logic [31:0] m;
    rst = 1'b1;
    ce = 1'b1;
    mask = 1'b0;
    in_de = 1'b0;
    in_vsync = 1'b0;
    repeat (3) tick();
    chk("rst_area", int'(area), 0);
    chk("rst_cxcy", int'({cx, cy}), 0);
    chk("rst_flags", int'({found, valid, busy, overrun}), 0);
    chk("rst_bbox", int'(|{bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}), 0);
    rst = 1'b0;
    tick();

    // Frame with no pixels after reset
    busy_seen = 1'b0;
    vsync_rise(32'd0, 1'b1, 0, t);
    wait_idle();
    chk("empty0_busy", int'(busy_seen), 0);

    // Single pixel at (5,3)
    m = 32'd1 << 29;
    send_lines(m, 8, 4);
    vsync_rise(m, 1'b1, 0, t);
    while (cyc < t + 30) tick();
    chk("busy_T30", int'(busy), 1);
    tick();
    chk("busy_T31", int'(busy), 0);
    wait_idle();

    // 2x2 block at x 2..3, y 1..2
    m = 32'h000C_0C00;
    send_lines(m, 8, 4);
    vsync_rise(m, 1'b1, 0, t);
    wait_idle();

    // Full frame plus out-of-range pixels, twice
    m = '1;
    for (int k = 0; k < 2; k++) begin
      send_lines(m, 10, 5);
      vsync_rise(m, 1'b1, 0, t);
      wait_idle();
    end

    // Empty frame with active lines
    send_lines(32'd0, 8, 4);
    busy_seen = 1'b0;
    vsync_rise(32'd0, 1'b1, 0, t);
    wait_idle();
    chk("empty_busy", int'(busy_seen), 0);

    // Second frame end 10 cycles into the division
    m = 32'h8040_0000;
    send_lines(m, 8, 4);
    no = n_ovr;
    vsync_rise(m, 1'b1, 0, t);
    while (cyc < t + 10) tick();
    vsync_rise(32'd0, 1'b0, 0, t2);
    wait_idle();
    chk("overrun_pulses", n_ovr - no, 1);

    // Reset in the middle of a division
    m = 32'd1 << 29;
    send_lines(m, 8, 4);
    vsync_rise(m, 1'b0, 0, t);
    while (cyc < t + 15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_area", int'(area), 0);
    chk("abort_cxcy", int'({cx, cy}), 0);
    chk("abort_flags", int'({found, valid, busy, overrun}), 0);
    nv = n_valid;
    repeat (40) tick();
    chk("abort_no_valid", n_valid - nv, 0);

    // Clock enable low for 5 cycles mid-division
    m = 32'h000C_0C00;
    send_lines(m, 8, 4);
    vsync_rise(m, 1'b1, 5, t);
    while (cyc < t + 10) tick();
    ce = 1'b0;
    repeat (5) tick();
    ce = 1'b1;
    wait_idle();

    chk("sb_drained", sb.size(), 0);
    chk("valid_total", n_valid, 8);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
